// File: rtl/mmu_mapper.sv
// Paged address mapper: translates CPU virtual addresses to SDRAM physical
// addresses through a per-context page map, with write protection, fault
// capture and a small byte-wide register window for software control.
module mmu_mapper #(
    parameter int VADDR_W = 16,
    parameter int PADDR_W = 25,
    parameter int PAGE_W  = 12,
    parameter int NCTX    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [VADDR_W-1:0] cpu_addr,
    input  logic               cpu_valid,
    input  logic               rw,
    input  logic               cs,
    input  logic [5:0]         reg_addr,
    input  logic [7:0]         i_data,
    output logic [7:0]         o_data,
    output logic [PADDR_W-1:0] sdram_addr,
    output logic               addr_valid,
    output logic               fault
);

    localparam int PN_W    = VADDR_W - PAGE_W;
    localparam int NPAGES  = 1 << PN_W;
    localparam int FRAME_W = PADDR_W - PAGE_W;
    localparam int NENT    = NCTX * NPAGES;
    localparam int IDX_W   = (NENT > 1) ? $clog2(NENT) : 1;

    // Map entries, flattened as context * NPAGES + page
    logic               ent_v     [NENT];
    logic               ent_wp    [NENT];
    logic [FRAME_W-1:0] ent_frame [NENT];

    logic       en;
    logic [1:0] active_ctx;
    logic [1:0] edit_ctx;
    logic [7:0] staging;
    logic       fault_sticky;
    logic       fault_was_write;
    logic [15:0] faddr;

    logic [3:0]         reg_page;
    logic               reg_is_entry;
    logic [IDX_W-1:0]   edit_idx;
    logic [IDX_W-1:0]   trans_idx;
    logic [7:0]         rd_data;
    logic               reg_wr;
    logic               xlat_req;
    logic               xlat_fault;
    logic [PADDR_W-1:0] xlat_addr;

    // Context numbers outside the implemented range fold back into it
    function automatic logic [1:0] wrap_ctx(input logic [1:0] v);
        wrap_ctx = 2'(int'(v) % NCTX);
    endfunction

    // Register window decode and index computation for edit and translation
    always_comb begin
        reg_page     = reg_addr[4:1];
        reg_is_entry = !reg_addr[5] && (int'(reg_page) < NPAGES);
        edit_idx     = IDX_W'(int'(edit_ctx) * NPAGES + int'(reg_page));
        trans_idx    = IDX_W'(int'(active_ctx) * NPAGES + int'(cpu_addr[VADDR_W-1:PAGE_W]));
        reg_wr       = cs && !rw;
        xlat_req     = cpu_valid && !cs;
    end

    // Read mux; low byte shows the committed frame, never the staging byte
    always_comb begin
        rd_data = 8'h00;
        if (reg_is_entry) begin
            if (!reg_addr[0])
                rd_data = ent_frame[edit_idx][7:0];
            else
                rd_data = {ent_v[edit_idx], ent_wp[edit_idx], 6'(ent_frame[edit_idx] >> 8)};
        end else begin
            case (reg_addr)
                6'h20:   rd_data = {edit_ctx, active_ctx, 3'b000, en};
                6'h21:   rd_data = {6'b000000, fault_was_write, fault_sticky};
                6'h22:   rd_data = faddr[7:0];
                6'h23:   rd_data = faddr[15:8];
                default: rd_data = 8'h00;
            endcase
        end
    end

    // Translation lookup: pass-through when disabled, page map when enabled
    always_comb begin
        xlat_fault = 1'b0;
        xlat_addr  = PADDR_W'(cpu_addr);
        if (en) begin
            xlat_fault = !ent_v[trans_idx] || (ent_wp[trans_idx] && !rw);
            xlat_addr  = {ent_frame[trans_idx], cpu_addr[PAGE_W-1:0]};
        end
    end

    // Map storage: identity map on reset, high-byte write commits the entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCTX; c++) begin
                for (int p = 0; p < NPAGES; p++) begin
                    ent_v[IDX_W'(c * NPAGES + p)]     <= 1'b1;
                    ent_wp[IDX_W'(c * NPAGES + p)]    <= 1'b0;
                    ent_frame[IDX_W'(c * NPAGES + p)] <= FRAME_W'(p);
                end
            end
        end else if (reg_wr && reg_is_entry && reg_addr[0]) begin
            ent_v[edit_idx]     <= i_data[7];
            ent_wp[edit_idx]    <= i_data[6];
            ent_frame[edit_idx] <= {i_data[FRAME_W-9:0], staging};
        end
    end

    // Control, status, fault capture and registered read data
    always_ff @(posedge clk) begin
        if (rst) begin
            en              <= 1'b0;
            active_ctx      <= 2'b00;
            edit_ctx        <= 2'b00;
            staging         <= 8'h00;
            fault_sticky    <= 1'b0;
            fault_was_write <= 1'b0;
            faddr           <= 16'h0000;
            o_data          <= 8'h00;
        end else begin
            if (cs && rw)
                o_data <= rd_data;
            if (reg_wr && reg_is_entry && !reg_addr[0])
                staging <= i_data;
            if (reg_wr && reg_addr == 6'h20) begin
                en         <= i_data[0];
                active_ctx <= wrap_ctx(i_data[5:4]);
                edit_ctx   <= wrap_ctx(i_data[7:6]);
            end
            if (reg_wr && reg_addr == 6'h21 && i_data[0]) begin
                fault_sticky    <= 1'b0;
                fault_was_write <= 1'b0;
            end
            if (xlat_req && xlat_fault && !fault_sticky) begin
                fault_sticky    <= 1'b1;
                fault_was_write <= !rw;
                faddr           <= 16'(cpu_addr);
            end
        end
    end

    // One-cycle translation result; a fault leaves the last address in place
    always_ff @(posedge clk) begin
        if (rst) begin
            sdram_addr <= '0;
            addr_valid <= 1'b0;
            fault      <= 1'b0;
        end else begin
            addr_valid <= 1'b0;
            fault      <= 1'b0;
            if (xlat_req) begin
                if (xlat_fault) begin
                    fault <= 1'b1;
                end else begin
                    addr_valid <= 1'b1;
                    sdram_addr <= xlat_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_mmu_mapper.sv
// Testbench for mmu_mapper: directed register and translation sequences,
// translation results checked by a queue-based scoreboard monitor.
module tb_mmu_mapper;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_valid;
    logic        rw;
    logic        cs;
    logic [5:0]  reg_addr;
    logic [7:0]  i_data;
    logic [7:0]  o_data;
    logic [24:0] sdram_addr;
    logic        addr_valid;
    logic        fault;

    typedef struct {
        logic        is_fault;
        logic [24:0] addr;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_exp;
    int   num_compared;
    int   num_mismatched;

    mmu_mapper #(
        .VADDR_W(16),
        .PADDR_W(25),
        .PAGE_W (12),
        .NCTX   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_valid (cpu_valid),
        .rw        (rw),
        .cs        (cs),
        .reg_addr  (reg_addr),
        .i_data    (i_data),
        .o_data    (o_data),
        .sdram_addr(sdram_addr),
        .addr_valid(addr_valid),
        .fault     (fault)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        num_compared++;
        if (actual !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs starting at a falling edge, then go idle
    task automatic applyStimulus(input logic in_cs, input logic in_rw, input logic [5:0] in_reg,
                                 input logic [7:0] in_data, input logic in_valid, input logic [15:0] in_addr);
        cs        = in_cs;
        rw        = in_rw;
        reg_addr  = in_reg;
        i_data    = in_data;
        cpu_valid = in_valid;
        cpu_addr  = in_addr;
        @(negedge clk);
        cs        = 1'b0;
        rw        = 1'b1;
        reg_addr  = 6'h00;
        i_data    = 8'h00;
        cpu_valid = 1'b0;
        cpu_addr  = 16'h0000;
    endtask

    task automatic regWrite(input logic [5:0] a, input logic [7:0] d);
        applyStimulus(1'b1, 1'b0, a, d, 1'b0, 16'h0000);
    endtask

    task automatic regRead(input string name, input logic [5:0] a, input logic [7:0] exp_data);
        applyStimulus(1'b1, 1'b1, a, 8'h00, 1'b0, 16'h0000);
        checkOutput(name, 32'(o_data), 32'(exp_data));
    endtask

    task automatic cpuAccess(input logic [15:0] a, input logic is_read, input logic exp_fault, input logic [24:0] exp_addr);
        exp_t e;
        e.is_fault = exp_fault;
        e.addr     = exp_addr;
        sb_q.push_back(e);
        applyStimulus(1'b0, is_read, 6'h00, 8'h00, 1'b1, a);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Scoreboard monitor: every response must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && (addr_valid || fault)) begin
            if (sb_q.size() == 0) begin
                num_compared++;
                num_mismatched++;
                $display("[TB] FAIL unexpected_response: got valid=%0b fault=%0b addr=0x%0h, expected none",
                         addr_valid, fault, sdram_addr);
            end else begin
                mon_exp = sb_q.pop_front();
                checkOutput("resp_kind", {30'd0, fault, addr_valid}, {30'd0, mon_exp.is_fault, !mon_exp.is_fault});
                checkOutput("resp_addr", 32'(sdram_addr), 32'(mon_exp.addr));
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        num_compared   = 0;
        num_mismatched = 0;
        rst       = 1'b1;
        cs        = 1'b0;
        rw        = 1'b1;
        reg_addr  = 6'h00;
        i_data    = 8'h00;
        cpu_valid = 1'b0;
        cpu_addr  = 16'h0000;
        idleCycles(3);
        rst = 1'b0;

        checkOutput("rst_addr_valid", 32'(addr_valid), 32'd0);
        checkOutput("rst_fault", 32'(fault), 32'd0);
        checkOutput("rst_sdram_addr", 32'(sdram_addr), 32'd0);
        checkOutput("rst_o_data", 32'(o_data), 32'd0);
        regRead("rst_ctrl", 6'h20, 8'h00);
        regRead("rst_status", 6'h21, 8'h00);
        regRead("rst_entry1_hi", 6'h03, 8'h80);

        // Pass-through with mapping disabled
        cpuAccess(16'hC123, 1'b1, 1'b0, 25'h000C123);

        // Remap page 3 to frame 0x200 and enable
        regWrite(6'h06, 8'h00);
        regWrite(6'h07, 8'h82);
        regWrite(6'h20, 8'h01);
        cpuAccess(16'h3ABC, 1'b1, 1'b0, 25'h0200ABC);
        regRead("p3_hi", 6'h07, 8'h82);
        regRead("p3_lo", 6'h06, 8'h00);

        // Low byte alone only stages
        regWrite(6'h08, 8'h55);
        regRead("p4_lo_staged", 6'h08, 8'h04);
        cpuAccess(16'h4123, 1'b1, 1'b0, 25'h0004123);
        regRead("unmapped_read", 6'h30, 8'h00);

        // Back-to-back translations
        cpuAccess(16'h1001, 1'b1, 1'b0, 25'h0001001);
        cpuAccess(16'h3FFF, 1'b0, 1'b0, 25'h0200FFF);
        cpuAccess(16'hF000, 1'b1, 1'b0, 25'h000F000);

        // Write-protect page 5, fault on write, reads still pass
        regWrite(6'h0A, 8'h05);
        regWrite(6'h0B, 8'hC0);
        cpuAccess(16'h5000, 1'b0, 1'b1, 25'h000F000);
        cpuAccess(16'h5004, 1'b1, 1'b0, 25'h0005004);
        regRead("status_after_wp", 6'h21, 8'h03);
        regRead("faddr_lo", 6'h22, 8'h00);
        regRead("faddr_hi", 6'h23, 8'h50);
        regWrite(6'h0C, 8'h06);
        checkOutput("o_data_hold", 32'(o_data), 32'h50);
        regWrite(6'h0D, 8'h00);
        cpuAccess(16'h6000, 1'b1, 1'b1, 25'h0005004);
        regRead("faddr_lo_kept", 6'h22, 8'h00);
        regRead("faddr_hi_kept", 6'h23, 8'h50);
        regRead("status_kept", 6'h21, 8'h03);
        regWrite(6'h21, 8'h01);
        regRead("status_cleared", 6'h21, 8'h00);

        // Edit context 1 while context 0 stays active
        regWrite(6'h20, 8'h41);
        regRead("ctrl_edit1", 6'h20, 8'h41);
        regWrite(6'h04, 8'h34);
        regWrite(6'h05, 8'h81);
        cpuAccess(16'h2345, 1'b1, 1'b0, 25'h0002345);
        regWrite(6'h20, 8'h11);
        regRead("ctx0_p2_hi", 6'h05, 8'h80);
        cpuAccess(16'h2345, 1'b1, 1'b0, 25'h0134345);
        cpuAccess(16'h5000, 1'b0, 1'b0, 25'h0005000);

        // Register access with cpu_valid: no translation response
        applyStimulus(1'b1, 1'b1, 6'h20, 8'h00, 1'b1, 16'h2345);
        checkOutput("cs_valid_ctrl", 32'(o_data), 32'h11);
        idleCycles(2);

        // Reset while a translation is being sampled
        rst       = 1'b1;
        cpu_valid = 1'b1;
        cpu_addr  = 16'h2345;
        rw        = 1'b1;
        idleCycles(1);
        cpu_valid = 1'b0;
        idleCycles(1);
        rst = 1'b0;
        sb_q.delete();
        checkOutput("rst2_addr_valid", 32'(addr_valid), 32'd0);
        checkOutput("rst2_sdram_addr", 32'(sdram_addr), 32'd0);
        regRead("rst2_ctrl", 6'h20, 8'h00);
        cpuAccess(16'h2345, 1'b1, 1'b0, 25'h0002345);
        regWrite(6'h20, 8'h11);
        cpuAccess(16'h2345, 1'b1, 1'b0, 25'h0002345);
        regWrite(6'h20, 8'h51);
        regRead("rst2_ctx1_p2_lo", 6'h04, 8'h02);
        regRead("rst2_ctx1_p2_hi", 6'h05, 8'h80);
        regWrite(6'h20, 8'h01);
        cpuAccess(16'h6000, 1'b1, 1'b0, 25'h0006000);
        cpuAccess(16'h5000, 1'b0, 1'b0, 25'h0005000);

        idleCycles(4);
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
